// File: rtl/trace_ctrl_pkg.sv
// ============================================================================
//  Module   : trace_ctrl_pkg
//  Brief    : Shared state encoding and depth helper for the trace capture
//             sequencer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package trace_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRE   = 3'd1,
        POST  = 3'd2,
        DONE  = 3'd3,
        ALIGN = 3'd4,
        READ  = 3'd5
    } tc_state_e;

    function automatic int tb_depth(input int aw);
        return 1 << aw;
    endfunction

endpackage

`default_nettype wire

// File: rtl/trace_trig_match.sv
// ============================================================================
//  Module   : trace_trig_match
//  Brief    : Masked-compare trigger detector; fire is combinational from the
//             inputs. TRACE_TRIG_OCC_EN adds an occurrence counter so fire
//             happens on the trig_occ-th match (0 treated as 1).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module trace_trig_match #(
    parameter int FPAY  = 32
`ifdef TRACE_TRIG_OCC_EN
    , parameter int OCC_W = 8
`endif
) (
`ifdef TRACE_TRIG_OCC_EN
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [OCC_W-1:0] trig_occ,
`endif
    input  logic             enable,
    input  logic [FPAY-1:0]  trace_in,
    input  logic             trace_valid,
    input  logic [FPAY-1:0]  trig_mask,
    input  logic [FPAY-1:0]  trig_value,
    output logic             fire
);

    logic w_match;

    assign w_match = trace_valid && (((trace_in ^ trig_value) & trig_mask) == '0);

`ifdef TRACE_TRIG_OCC_EN
    logic [OCC_W-1:0] r_occ_cnt;
    logic [OCC_W-1:0] w_occ_nxt;
    logic [OCC_W-1:0] w_occ_tgt;

    assign w_occ_nxt = r_occ_cnt + 1'b1;
    assign w_occ_tgt = (trig_occ == '0) ? OCC_W'(1) : trig_occ;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_occ_cnt <= '0;
        end else if (enable && w_match) begin
            r_occ_cnt <= w_occ_nxt;
        end
    end

    assign fire = enable && w_match && (w_occ_nxt == w_occ_tgt);
`else
    assign fire = enable && w_match;
`endif

endmodule

`default_nettype wire

// File: rtl/trace_capture_ctrl.sv
// ============================================================================
//  Module   : trace_capture_ctrl
//  Brief    : Capture/readout sequencer for the debug trace buffer: circular
//             pre-trigger capture, post-trigger count, freeze, and oldest-first
//             readout with dummy-read pointer alignment.
//             Optional macro: TRACE_TRIG_OCC_EN (trigger occurrence count).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module trace_capture_ctrl
    import trace_ctrl_pkg::*;
#(
    parameter int FPAY  = 32,
    parameter int TB_AW = 9
`ifdef TRACE_TRIG_OCC_EN
    , parameter int OCC_W = 8
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arm,
    input  logic              disarm,
    input  logic [FPAY-1:0]   trace_in,
    input  logic              trace_valid,
    input  logic [FPAY-1:0]   trig_mask,
    input  logic [FPAY-1:0]   trig_value,
    input  logic [TB_AW-1:0]  post_count,
`ifdef TRACE_TRIG_OCC_EN
    input  logic [OCC_W-1:0]  trig_occ,
`endif
    input  logic              rd_req,
    output logic [FPAY-1:0]   tb_trace,
    output logic              tb_wr,
    output logic              tb_rd,
    output logic              rd_valid,
    output logic              triggered,
    output logic              done,
    output logic [TB_AW:0]    stored,
    output logic [2:0]        state
);

    localparam int               c_tb_depth    = tb_depth(TB_AW);
    localparam logic [TB_AW:0]   c_stored_full = (TB_AW+1)'(c_tb_depth);
    localparam logic [TB_AW:0]   c_stored_one  = (TB_AW+1)'(1);
    localparam logic [TB_AW-1:0] c_post_one    = TB_AW'(1);

    tc_state_e        r_state;
    tc_state_e        w_state_nxt;
    logic [FPAY-1:0]  r_tb_trace;
    logic             r_tb_wr;
    logic             r_tb_rd;
    logic             r_rd_valid;
    logic             r_triggered;
    logic [TB_AW:0]   r_stored;
    logic [TB_AW-1:0] r_wr_m;
    logic [TB_AW-1:0] r_rd_m;
    logic [TB_AW-1:0] r_post_len;
    logic [TB_AW-1:0] r_post_cnt;
    logic             r_rd_pend;

    logic             w_fire;
    logic             w_arm_go;
    logic             w_wr_go;
    logic             w_rd_go;
    logic             w_dummy_go;
    logic             w_trig_go;
    logic             w_post_first;
    logic             w_post_step;
    logic             w_pend_nxt;
    logic [TB_AW-1:0] w_post_inc;
    logic [TB_AW-1:0] w_align_tgt;

    assign w_post_inc  = r_post_cnt + 1'b1;
    // Oldest valid word sits 'stored' entries behind the write pointer.
    assign w_align_tgt = r_wr_m - r_stored[TB_AW-1:0];

    trace_trig_match #(
        .FPAY(FPAY)
`ifdef TRACE_TRIG_OCC_EN
        , .OCC_W(OCC_W)
`endif
    ) u_trig_match (
`ifdef TRACE_TRIG_OCC_EN
        .clk         (clk),
        .reset       (reset),
        .clear       (w_arm_go),
        .trig_occ    (trig_occ),
`endif
        .enable      (r_state == PRE),
        .trace_in    (trace_in),
        .trace_valid (trace_valid),
        .trig_mask   (trig_mask),
        .trig_value  (trig_value),
        .fire        (w_fire)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_arm_go     = 1'b0;
        w_wr_go      = 1'b0;
        w_rd_go      = 1'b0;
        w_dummy_go   = 1'b0;
        w_trig_go    = 1'b0;
        w_post_first = 1'b0;
        w_post_step  = 1'b0;
        w_pend_nxt   = r_rd_pend;
        if (disarm) begin
            w_state_nxt = IDLE;
            w_pend_nxt  = 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (arm) begin
                        w_arm_go    = 1'b1;
                        w_state_nxt = PRE;
                    end
                end
                PRE: begin
                    if (w_fire) begin
                        w_trig_go = 1'b1;
                        if (r_post_len == '0) begin
                            w_state_nxt = DONE;
                        end else begin
                            w_wr_go      = 1'b1;
                            w_post_first = 1'b1;
                            w_state_nxt  = (r_post_len == c_post_one) ? DONE : POST;
                        end
                    end else begin
                        w_wr_go = trace_valid;
                    end
                end
                POST: begin
                    if (trace_valid) begin
                        w_wr_go     = 1'b1;
                        w_post_step = 1'b1;
                        if (w_post_inc == r_post_len) begin
                            w_state_nxt = DONE;
                        end
                    end
                end
                DONE: begin
                    if (arm) begin
                        w_arm_go    = 1'b1;
                        w_state_nxt = PRE;
                    end else if (rd_req) begin
                        // The triggering request is kept pending and serviced in READ.
                        if (r_stored == c_stored_full) begin
                            w_state_nxt = ALIGN;
                            w_pend_nxt  = 1'b1;
                        end else if (r_stored == '0) begin
                            w_state_nxt = IDLE;
                        end else begin
                            w_state_nxt = READ;
                            w_pend_nxt  = 1'b1;
                        end
                    end
                end
                ALIGN: begin
                    if (r_rd_m == w_align_tgt) begin
                        w_state_nxt = READ;
                    end else begin
                        w_dummy_go = 1'b1;
                    end
                end
                READ: begin
                    if (r_stored == '0) begin
                        w_state_nxt = IDLE;
                        w_pend_nxt  = 1'b0;
                    end else if (r_rd_pend || rd_req) begin
                        w_rd_go    = 1'b1;
                        w_pend_nxt = r_rd_pend && rd_req;
                        if (r_stored == c_stored_one) begin
                            w_state_nxt = IDLE;
                            w_pend_nxt  = 1'b0;
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_tb_trace  <= '0;
            r_tb_wr     <= 1'b0;
            r_tb_rd     <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_triggered <= 1'b0;
            r_stored    <= '0;
            r_wr_m      <= '0;
            r_rd_m      <= '0;
            r_post_len  <= '0;
            r_post_cnt  <= '0;
            r_rd_pend   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rd_pend  <= w_pend_nxt;
            r_tb_wr    <= w_wr_go;
            r_tb_rd    <= w_rd_go || w_dummy_go;
            r_rd_valid <= w_rd_go;
            if (w_wr_go) begin
                r_tb_trace <= trace_in;
            end
            if (w_post_first) begin
                r_post_cnt <= c_post_one;
            end else if (w_post_step) begin
                r_post_cnt <= w_post_inc;
            end
            if (w_arm_go) begin
                // Logical restart: no buffer reset, read mirror jumps to write mirror.
                r_post_len  <= post_count;
                r_stored    <= '0;
                r_triggered <= 1'b0;
                r_rd_m      <= r_wr_m;
            end else begin
                if (w_trig_go) begin
                    r_triggered <= 1'b1;
                end
                if (w_wr_go) begin
                    r_wr_m <= r_wr_m + 1'b1;
                    if (r_stored != c_stored_full) begin
                        r_stored <= r_stored + 1'b1;
                    end
                end
                if (w_rd_go) begin
                    r_rd_m   <= r_rd_m + 1'b1;
                    r_stored <= r_stored - 1'b1;
                end
                if (w_dummy_go) begin
                    r_rd_m <= r_rd_m + 1'b1;
                end
            end
        end
    end

    assign tb_trace  = r_tb_trace;
    assign tb_wr     = r_tb_wr;
    assign tb_rd     = r_tb_rd;
    assign rd_valid  = r_rd_valid;
    assign triggered = r_triggered;
    assign stored    = r_stored;
    assign state     = r_state;
    assign done      = (r_state == DONE) || (r_state == ALIGN) || (r_state == READ);

endmodule

`default_nettype wire

// File: tb/tb_trace_capture_ctrl.sv
// ============================================================================
//  Module   : tb_trace_capture_ctrl
//  Brief    : Self-checking bench with a trace buffer model and a read-data
//             scoreboard for trace_capture_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_trace_capture_ctrl;
    import trace_ctrl_pkg::*;

    localparam int FPAY  = 32;
    localparam int TB_AW = 9;
    localparam int DEPTH = 1 << TB_AW;

    logic             clk = 1'b0;
    logic             reset;
    logic             arm;
    logic             disarm;
    logic [FPAY-1:0]  trace_in;
    logic             trace_valid;
    logic [FPAY-1:0]  trig_mask;
    logic [FPAY-1:0]  trig_value;
    logic [TB_AW-1:0] post_count;
`ifdef TRACE_TRIG_OCC_EN
    logic [7:0]       trig_occ;
`endif
    logic             rd_req;
    logic [FPAY-1:0]  tb_trace;
    logic             tb_wr;
    logic             tb_rd;
    logic             rd_valid;
    logic             triggered;
    logic             done;
    logic [TB_AW:0]   stored;
    logic [2:0]       state;

    always #5 clk = ~clk;

    trace_capture_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .arm         (arm),
        .disarm      (disarm),
        .trace_in    (trace_in),
        .trace_valid (trace_valid),
        .trig_mask   (trig_mask),
        .trig_value  (trig_value),
        .post_count  (post_count),
`ifdef TRACE_TRIG_OCC_EN
        .trig_occ    (trig_occ),
`endif
        .rd_req      (rd_req),
        .tb_trace    (tb_trace),
        .tb_wr       (tb_wr),
        .tb_rd       (tb_rd),
        .rd_valid    (rd_valid),
        .triggered   (triggered),
        .done        (done),
        .stored      (stored),
        .state       (state)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Trace buffer model: free-running pointers, registered read data.
    logic [FPAY-1:0]  bmem [DEPTH];
    logic [TB_AW-1:0] bwp;
    logic [TB_AW-1:0] brp;
    logic [FPAY-1:0]  bdout;

    always @(posedge clk) begin
        if (reset) begin
            bwp   <= '0;
            brp   <= '0;
            bdout <= '0;
        end else begin
            if (tb_wr) begin
                bmem[bwp] <= tb_trace;
                bwp       <= bwp + 1'b1;
            end
            if (tb_rd) begin
                bdout <= bmem[brp];
                brp   <= brp + 1'b1;
            end
        end
    end

    logic [FPAY-1:0] sb [$];
    logic [FPAY-1:0] last_rd;
    logic            rdv_d       = 1'b0;
    int              wr_cnt      = 0;
    int              rd_cnt      = 0;
    int              dummy_cnt   = 0;
    int              overlap_cnt = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (rdv_d) begin
                check("sb_nonempty", (sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    last_rd = bdout;
                    check("rd_data", bdout, sb.pop_front());
                end
            end
            rdv_d = tb_rd && rd_valid && !reset;
            if (!reset) begin
                if (tb_wr) wr_cnt++;
                if (tb_rd) rd_cnt++;
                if (tb_rd && !rd_valid) dummy_cnt++;
                if (tb_wr && tb_rd) overlap_cnt++;
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget, input string tag);
        int k = 0;
        while (state !== st && k < budget) begin
            tick();
            k++;
        end
        check(tag, state, st);
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int wr_base;
        int rd_base;
        int dm_base;
        reset       = 1'b1;
        arm         = 1'b0;
        disarm      = 1'b0;
        trace_in    = '0;
        trace_valid = 1'b0;
        trig_mask   = '0;
        trig_value  = '0;
        post_count  = '0;
`ifdef TRACE_TRIG_OCC_EN
        trig_occ    = '0;
`endif
        rd_req      = 1'b0;
        tick(3);
        reset = 1'b0;
        tick();
        check("rst_state", state, IDLE);
        check("rst_tb_wr", tb_wr, 0);
        check("rst_tb_rd", tb_rd, 0);
        check("rst_done", done, 0);
        check("rst_stored", stored, 0);
        check("rst_triggered", triggered, 0);

        // Mask 0: first valid word triggers, four samples kept.
        trig_mask  = '0;
        trig_value = '1;
        post_count = 9'd4;
        pulse_arm();
        check("t1_state_pre", state, PRE);
        wr_base = wr_cnt;
        for (int i = 0; i < 10; i++) begin
            trace_in    = 32'h1000 + i;
            trace_valid = 1'b1;
            if (i < 4) sb.push_back(32'h1000 + i);
            tick();
        end
        trace_valid = 1'b0;
        tick(2);
        check("t1_wr_count", wr_cnt - wr_base, 4);
        check("t1_triggered", triggered, 1);
        check("t1_done", done, 1);
        check("t1_stored", stored, 4);
        check("t1_state_done", state, DONE);
        for (int i = 0; i < 4; i++) begin
            rd_req = 1'b1;
            tick();
        end
        rd_req = 1'b0;
        wait_state(IDLE, 20, "t1_idle");
        tick(3);
        check("t1_sb_drained", sb.size(), 0);
        check("t1_done_clear", done, 0);

        // Buffer wraps: 512 pre words, trigger at cycle 700, 8 post words.
        trig_mask  = '1;
        trig_value = 32'hDEAD_BEEF;
        post_count = 9'd8;
        pulse_arm();
        for (int c = 0; c < 700; c++) begin
            trace_valid = (c < 512);
            trace_in    = c;
            if (c >= 8 && c < 512) sb.push_back(c);
            tick();
        end
        check("t2_not_triggered", triggered, 0);
        for (int j = 0; j < 8; j++) begin
            trace_valid = 1'b1;
            trace_in    = 32'hDEAD_BEEF + j;
            sb.push_back(32'hDEAD_BEEF + j);
            tick();
        end
        trace_valid = 1'b0;
        tick(2);
        check("t2_stored_full", stored, DEPTH);
        check("t2_state_done", state, DONE);
        check("t2_triggered", triggered, 1);
        dm_base = dummy_cnt;
        rd_req  = 1'b1;
        tick();
        rd_req = 1'b0;
        check("t2_state_align", state, ALIGN);
        wait_state(READ, 40, "t2_read");
        check("t2_dummy_reads", dummy_cnt - dm_base, 8);
        for (int i = 0; i < DEPTH - 1; i++) begin
            rd_req = 1'b1;
            tick();
        end
        rd_req = 1'b0;
        wait_state(IDLE, 40, "t2_idle");
        tick(3);
        check("t2_sb_drained", sb.size(), 0);
        check("t2_last_word", last_rd, 32'hDEAD_BEEF + 7);
        check("t2_stored_zero", stored, 0);

        // post_count 0: trigger word not written.
        trig_mask  = '1;
        trig_value = 32'h0000_0055;
        post_count = 9'd0;
        pulse_arm();
        wr_base = wr_cnt;
        for (int i = 0; i < 5; i++) begin
            trace_valid = 1'b1;
            trace_in    = 32'h100 + i;
            sb.push_back(32'h100 + i);
            tick();
        end
        trace_in = 32'h0000_0055;
        tick();
        trace_valid = 1'b0;
        tick(2);
        check("t3_state_done", state, DONE);
        check("t3_stored", stored, 5);
        check("t3_wr_count", wr_cnt - wr_base, 5);
        check("t3_triggered", triggered, 1);
        for (int i = 0; i < 5; i++) begin
            rd_req = 1'b1;
            tick();
            rd_req = 1'b0;
            tick(2);
        end
        wait_state(IDLE, 20, "t3_idle");
        tick(2);
        check("t3_sb_drained", sb.size(), 0);

        // rd_req in IDLE produces no buffer read.
        rd_base = rd_cnt;
        rd_req  = 1'b1;
        tick();
        rd_req = 1'b0;
        tick(2);
        check("idle_no_rd", rd_cnt - rd_base, 0);

        // disarm in POST after two of five samples.
        trig_mask  = '0;
        post_count = 9'd5;
        pulse_arm();
        wr_base = wr_cnt;
        trace_valid = 1'b1;
        trace_in    = 32'hA0;
        tick();
        trace_in = 32'hA1;
        tick();
        check("t4_state_post", state, POST);
        trace_in = 32'hA2;
        disarm   = 1'b1;
        tick();
        disarm      = 1'b0;
        trace_valid = 1'b0;
        check("t4_state_idle", state, IDLE);
        check("t4_tb_wr", tb_wr, 0);
        check("t4_done", done, 0);
        tick(2);
        check("t4_wr_count", wr_cnt - wr_base, 2);

        // arm+disarm in DONE; arm+match in IDLE.
        post_count = 9'd1;
        pulse_arm();
        trace_valid = 1'b1;
        trace_in    = 32'hB0;
        tick();
        trace_valid = 1'b0;
        tick(2);
        check("t5_state_done", state, DONE);
        arm    = 1'b1;
        disarm = 1'b1;
        tick();
        arm    = 1'b0;
        disarm = 1'b0;
        check("t5_disarm_wins", state, IDLE);
        arm         = 1'b1;
        trace_valid = 1'b1;
        trace_in    = 32'hB1;
        tick();
        arm         = 1'b0;
        trace_valid = 1'b0;
        check("t5_arm_state", state, PRE);
        tick();
        check("t5_arm_no_trig", triggered, 0);
        check("t5_still_pre", state, PRE);
        disarm = 1'b1;
        tick();
        disarm = 1'b0;

`ifdef TRACE_TRIG_OCC_EN
        // Third occurrence fires the trigger.
        trig_mask  = '1;
        trig_value = 32'h0000_00A5;
        trig_occ   = 8'd3;
        post_count = 9'd2;
        pulse_arm();
        for (int c = 0; c < 20; c++) begin
            trace_valid = 1'b1;
            trace_in    = (c == 5 || c == 9 || c == 14) ? 32'h0000_00A5 : 32'h2000 + c;
            tick();
            if (c == 9)  check("occ_no_trig_2nd", triggered, 0);
            if (c == 13) check("occ_no_trig_13", triggered, 0);
            if (c == 14) check("occ_trig_3rd", triggered, 1);
        end
        trace_valid = 1'b0;
        disarm = 1'b1;
        tick();
        disarm = 1'b0;
        tick();
`endif

        check("no_wr_rd_overlap", overlap_cnt, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
